// File: rtl/pong_game_engine_if.sv
// Pong engine I/O bundle: frame tick, buttons and serve in;
// registered ball, paddle, score and state values out.
interface pong_game_engine_if;
    logic       iFrame_tick;
    logic       iP1_up;
    logic       iP1_dn;
    logic       iP2_up;
    logic       iP2_dn;
    logic       iServe;
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic [9:0] plat1X;
    logic [9:0] plat1Y;
    logic [9:0] plat2X;
    logic [9:0] plat2Y;
    logic [9:0] plat1H;
    logic [9:0] plat2H;
    logic [4:0] Score1;
    logic [4:0] Score2;
    logic [1:0] oState;

    modport master (
        output iFrame_tick, iP1_up, iP1_dn,
        output iP2_up, iP2_dn, iServe,
        input  ballX, ballY,
        input  plat1X, plat1Y, plat2X, plat2Y,
        input  plat1H, plat2H,
        input  Score1, Score2, oState
    );

    modport slave (
        input  iFrame_tick, iP1_up, iP1_dn,
        input  iP2_up, iP2_dn, iServe,
        output ballX, ballY,
        output plat1X, plat1Y, plat2X, plat2Y,
        output plat1H, plat2H,
        output Score1, Score2, oState
    );
endinterface

// File: rtl/pong_game_engine.sv
// Frame-rate Pong logic: paddles, ball motion, bounces, misses,
// scoring and the IDLE/PLAY/POINT/GAMEOVER flow.
module pong_game_engine #(
    parameter int BALL_SPEED   = 2,
    parameter int PAD_SPEED    = 4,
    parameter int PAD_H        = 60,
    parameter int PLAT1_X      = 20,
    parameter int PLAT2_X      = 610,
    parameter int WIN_SCORE    = 15,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic               iCLK,
    input  logic               iRST,
    pong_game_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_POINT = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int PW = $clog2(PAUSE_FRAMES + 1);

    localparam logic [9:0] C_BS      = 10'(BALL_SPEED);
    localparam logic [9:0] C_PS      = 10'(PAD_SPEED);
    localparam logic [9:0] C_PH      = 10'(PAD_H);
    localparam logic [9:0] C_PAD_MIN = 10'd5;
    localparam logic [9:0] C_PAD_MAX = 10'(475 - PAD_H);
    localparam logic [9:0] C_L_EDGE  = 10'(PLAT1_X + 14);
    localparam logic [9:0] C_R_EDGE  = 10'(PLAT2_X - 4);
    localparam logic [9:0] C_X_MIN   = 10'd5;
    localparam logic [9:0] C_X_MAX   = 10'd634;
    localparam logic [9:0] C_Y_MIN   = 10'd9;
    localparam logic [9:0] C_Y_MAX   = 10'd470;
    localparam logic [9:0] C_CX      = 10'd320;
    localparam logic [9:0] C_CY      = 10'd240;
    localparam logic [9:0] C_PAD0    = 10'd210;
    localparam logic [4:0] C_WIN     = 5'(WIN_SCORE);
    localparam logic [PW-1:0] C_PLAST = PW'(PAUSE_FRAMES - 1);
    localparam logic [PW-1:0] C_PONE  = PW'(1);

    state_t        r_state;
    logic [9:0]    r_ball_x;
    logic [9:0]    r_ball_y;
    logic          r_dx;
    logic          r_dy;
    logic [9:0]    r_p1_y;
    logic [9:0]    r_p2_y;
    logic [4:0]    r_score1;
    logic [4:0]    r_score2;
    logic [PW-1:0] r_pause;

    state_t        w_state_nxt;
    logic [9:0]    w_ball_x_nxt;
    logic [9:0]    w_ball_y_nxt;
    logic          w_dx_nxt;
    logic          w_dy_nxt;
    logic [9:0]    w_p1_y_nxt;
    logic [9:0]    w_p2_y_nxt;
    logic [4:0]    w_score1_nxt;
    logic [4:0]    w_score2_nxt;
    logic [PW-1:0] w_pause_nxt;

    logic          w_band1;
    logic          w_band2;
    logic          w_lhit;
    logic          w_rhit;
    logic          w_lmiss;
    logic          w_rmiss;
    logic [4:0]    w_s1_inc;
    logic [4:0]    w_s2_inc;
    logic [9:0]    w_x_mv;
    logic [9:0]    w_y_mv;
    logic          w_dy_mv;

    // Paddle step with clamping; the lower bound is checked
    // before subtracting so Y never wraps below zero.
    function automatic logic [9:0] f_pad(
        input logic [9:0] y,
        input logic       up,
        input logic       dn
    );
        logic [9:0] v;
        v = y;
        if (up && !dn) begin
            v = (y >= C_PAD_MIN + C_PS) ? y - C_PS : C_PAD_MIN;
        end else if (dn && !up) begin
            v = (y + C_PS <= C_PAD_MAX) ? y + C_PS : C_PAD_MAX;
        end
        return v;
    endfunction

    // Collision and miss decisions from pre-tick positions.
    assign w_band1  = (r_ball_y + 10'd3 >= r_p1_y) &&
                      (r_ball_y <= r_p1_y + C_PH + 10'd3);
    assign w_band2  = (r_ball_y + 10'd3 >= r_p2_y) &&
                      (r_ball_y <= r_p2_y + C_PH + 10'd3);
    assign w_lhit   = !r_dx && (r_ball_x >= C_L_EDGE) &&
                      (r_ball_x < C_L_EDGE + C_BS) && w_band1;
    assign w_rhit   = r_dx && (r_ball_x <= C_R_EDGE) &&
                      (r_ball_x + C_BS > C_R_EDGE) && w_band2;
    assign w_lmiss  = !r_dx && (r_ball_x < C_X_MIN + C_BS);
    assign w_rmiss  = r_dx && (r_ball_x + C_BS > C_X_MAX);
    assign w_s1_inc = r_score1 + 5'd1;
    assign w_s2_inc = r_score2 + 5'd1;
    assign w_x_mv   = r_dx ? r_ball_x + C_BS : r_ball_x - C_BS;

    // Vertical step with wall clamp and direction flip.
    always_comb begin
        w_y_mv  = r_ball_y;
        w_dy_mv = r_dy;
        if (r_dy) begin
            if (r_ball_y + C_BS > C_Y_MAX) begin
                w_y_mv  = C_Y_MAX;
                w_dy_mv = 1'b0;
            end else begin
                w_y_mv  = r_ball_y + C_BS;
            end
        end else begin
            if (r_ball_y < C_Y_MIN + C_BS) begin
                w_y_mv  = C_Y_MIN;
                w_dy_mv = 1'b1;
            end else begin
                w_y_mv  = r_ball_y - C_BS;
            end
        end
    end

    // Next-state and next-value logic; only tick cycles update.
    always_comb begin
        w_state_nxt  = r_state;
        w_ball_x_nxt = r_ball_x;
        w_ball_y_nxt = r_ball_y;
        w_dx_nxt     = r_dx;
        w_dy_nxt     = r_dy;
        w_p1_y_nxt   = r_p1_y;
        w_p2_y_nxt   = r_p2_y;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_pause_nxt  = r_pause;
        if (bus.iFrame_tick) begin
            if (r_state != S_OVER) begin
                w_p1_y_nxt = f_pad(r_p1_y, bus.iP1_up, bus.iP1_dn);
                w_p2_y_nxt = f_pad(r_p2_y, bus.iP2_up, bus.iP2_dn);
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.iServe) begin
                        w_state_nxt = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (w_lmiss || w_rmiss) begin
                        w_ball_x_nxt = C_CX;
                        w_ball_y_nxt = C_CY;
                        w_dx_nxt     = w_rmiss;
                        w_pause_nxt  = '0;
                        if (w_lmiss) begin
                            w_score2_nxt = w_s2_inc;
                            w_state_nxt  = (w_s2_inc == C_WIN) ?
                                           S_OVER : S_POINT;
                        end else begin
                            w_score1_nxt = w_s1_inc;
                            w_state_nxt  = (w_s1_inc == C_WIN) ?
                                           S_OVER : S_POINT;
                        end
                    end else begin
                        w_ball_y_nxt = w_y_mv;
                        w_dy_nxt     = w_dy_mv;
                        unique case (1'b1)
                            w_lhit: begin
                                w_ball_x_nxt = C_L_EDGE;
                                w_dx_nxt     = 1'b1;
                            end
                            w_rhit: begin
                                w_ball_x_nxt = C_R_EDGE;
                                w_dx_nxt     = 1'b0;
                            end
                            default: begin
                                w_ball_x_nxt = w_x_mv;
                            end
                        endcase
                    end
                end
                S_POINT: begin
                    w_pause_nxt = r_pause + C_PONE;
                    if (r_pause == C_PLAST) begin
                        w_state_nxt = S_PLAY;
                    end
                end
                S_OVER: begin
                    if (bus.iServe) begin
                        w_score1_nxt = '0;
                        w_score2_nxt = '0;
                        w_ball_x_nxt = C_CX;
                        w_ball_y_nxt = C_CY;
                        w_dx_nxt     = 1'b1;
                        w_state_nxt  = S_PLAY;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register; reset overrides a coincident tick.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= S_IDLE;
            r_ball_x <= C_CX;
            r_ball_y <= C_CY;
            r_dx     <= 1'b1;
            r_dy     <= 1'b1;
            r_p1_y   <= C_PAD0;
            r_p2_y   <= C_PAD0;
            r_score1 <= '0;
            r_score2 <= '0;
            r_pause  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ball_x <= w_ball_x_nxt;
            r_ball_y <= w_ball_y_nxt;
            r_dx     <= w_dx_nxt;
            r_dy     <= w_dy_nxt;
            r_p1_y   <= w_p1_y_nxt;
            r_p2_y   <= w_p2_y_nxt;
            r_score1 <= w_score1_nxt;
            r_score2 <= w_score2_nxt;
            r_pause  <= w_pause_nxt;
        end
    end

    assign bus.ballX  = r_ball_x;
    assign bus.ballY  = r_ball_y;
    assign bus.plat1X = 10'(PLAT1_X);
    assign bus.plat2X = 10'(PLAT2_X);
    assign bus.plat1Y = r_p1_y;
    assign bus.plat2Y = r_p2_y;
    assign bus.plat1H = C_PH;
    assign bus.plat2H = C_PH;
    assign bus.Score1 = r_score1;
    assign bus.Score2 = r_score2;
    assign bus.oState = r_state;

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: paddle table, full
// rallies with hand-derived positions, game over and reset.
module tb_pong_game_engine;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pong_game_engine_if bus();

    pong_game_engine dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic u1;
        logic d1;
        logic u2;
        logic d2;
        int   p1;
        int   p2;
    } pvec_t;

    pvec_t vt [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One tick cycle followed by one idle cycle, buttons held.
    task automatic tick(input logic u1, input logic d1,
                        input logic u2, input logic d2,
                        input logic sv);
        bus.iP1_up      = u1;
        bus.iP1_dn      = d1;
        bus.iP2_up      = u2;
        bus.iP2_dn      = d2;
        bus.iServe      = sv;
        bus.iFrame_tick = 1'b1;
        step();
        bus.iFrame_tick = 1'b0;
        step();
        bus.iServe      = 1'b0;
    endtask

    task automatic chk_ball(input string nm, input int x, input int y);
        chk({nm, ".x"}, int'(bus.ballX), x);
        chk({nm, ".y"}, int'(bus.ballY), y);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vt[0] = '{0, 0, 0, 0, 210, 210};
        vt[1] = '{1, 0, 0, 0, 206, 210};
        vt[2] = '{0, 1, 1, 0, 210, 206};
        vt[3] = '{1, 1, 0, 1, 210, 210};
        vt[4] = '{0, 0, 0, 1, 210, 214};
        vt[5] = '{1, 0, 1, 0, 206, 210};
        vt[6] = '{0, 1, 0, 1, 210, 214};
        vt[7] = '{0, 0, 1, 1, 210, 214};

        rst             = 1'b1;
        bus.iFrame_tick = 1'b0;
        bus.iP1_up      = 1'b0;
        bus.iP1_dn      = 1'b0;
        bus.iP2_up      = 1'b0;
        bus.iP2_dn      = 1'b0;
        bus.iServe      = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_ball("rst", 320, 240);
        chk("rst.p1y", int'(bus.plat1Y), 210);
        chk("rst.p2y", int'(bus.plat2Y), 210);
        chk("rst.h", int'(bus.plat1H), 60);
        chk("rst.st", int'(bus.oState), 0);

        // Serve level without a tick must not leave IDLE.
        bus.iServe = 1'b1;
        step();
        step();
        bus.iServe = 1'b0;
        chk("idle.notick", int'(bus.oState), 0);

        for (int i = 0; i < 8; i++) begin
            tick(vt[i].u1, vt[i].d1, vt[i].u2, vt[i].d2, 1'b0);
            chk($sformatf("vec%0d.p1", i), int'(bus.plat1Y), vt[i].p1);
            chk($sformatf("vec%0d.p2", i), int'(bus.plat2Y), vt[i].p2);
            chk($sformatf("vec%0d.st", i), int'(bus.oState), 0);
            chk($sformatf("vec%0d.x", i), int'(bus.ballX), 320);
        end

        for (int i = 1; i <= 60; i++) begin
            tick(1, 0, 0, 1, 0);
            if (i == 51) begin
                chk("clamp51.p1", int'(bus.plat1Y), 6);
                chk("clamp51.p2", int'(bus.plat2Y), 415);
            end
        end
        chk("clamp.p1", int'(bus.plat1Y), 5);
        chk("clamp.p2", int'(bus.plat2Y), 415);
        tick(1, 1, 0, 1, 0);
        chk("both.p1", int'(bus.plat1Y), 5);
        chk("dnmax.p2", int'(bus.plat2Y), 415);

        tick(0, 0, 0, 0, 1);
        chk("serve.st", int'(bus.oState), 1);
        chk_ball("serve", 320, 240);

        // Rally 1: right paddle returns, left paddle at 5 misses.
        for (int k = 1; k <= 445; k++) begin
            tick(0, 0, 0, 0, 0);
            if (k == 1)   chk_ball("r1.k1", 322, 242);
            if (k == 115) chk("r1.y115", int'(bus.ballY), 470);
            if (k == 116) chk("r1.y116", int'(bus.ballY), 470);
            if (k == 117) chk("r1.y117", int'(bus.ballY), 468);
            if (k == 143) chk("r1.x143", int'(bus.ballX), 606);
            if (k == 144) chk("r1.x144", int'(bus.ballX), 606);
            if (k == 145) chk("r1.x145", int'(bus.ballX), 604);
            if (k == 346) chk("r1.y346", int'(bus.ballY), 10);
            if (k == 347) chk("r1.y347", int'(bus.ballY), 9);
            if (k == 348) chk("r1.y348", int'(bus.ballY), 11);
            if (k == 430) chk_ball("r1.k430", 34, 175);
            if (k == 431) chk("r1.x431", int'(bus.ballX), 32);
            if (k == 444) chk("r1.x444", int'(bus.ballX), 6);
        end
        chk("miss1.st", int'(bus.oState), 2);
        chk_ball("miss1", 320, 240);
        chk("miss1.s2", int'(bus.Score2), 1);
        chk("miss1.s1", int'(bus.Score1), 0);

        // Rally 2: pause, left hit, right hit, left miss.
        for (int c = 1; c <= 792; c++) begin
            int r;
            r = c - 60;
            tick(0, c <= 103, c <= 66, 0, (c % 7) == 0);
            if (c == 59)  chk("pause59.st", int'(bus.oState), 2);
            if (c == 60) begin
                chk("pause60.st", int'(bus.oState), 1);
                chk("pause60.x", int'(bus.ballX), 320);
            end
            if (r == 1)   chk_ball("r2.r1", 318, 242);
            if (r == 143) begin
                chk_ball("r2.r143", 34, 416);
                chk("r2.p1", int'(bus.plat1Y), 415);
                chk("r2.p2", int'(bus.plat2Y), 151);
            end
            if (r == 144) chk_ball("r2.lhit", 34, 414);
            if (r == 145) chk_ball("r2.r145", 36, 412);
            if (r == 430) chk_ball("r2.r430", 606, 175);
            if (r == 431) chk_ball("r2.rhit", 606, 177);
            if (r == 432) chk("r2.x432", int'(bus.ballX), 604);
            if (r == 577) chk("r2.y577", int'(bus.ballY), 469);
            if (r == 578) chk("r2.y578", int'(bus.ballY), 470);
            if (r == 579) chk("r2.y579", int'(bus.ballY), 468);
            if (r == 717) chk_ball("r2.r717", 34, 192);
            if (r == 731) chk("r2.x731", int'(bus.ballX), 6);
        end
        chk("miss2.st", int'(bus.oState), 2);
        chk("miss2.s2", int'(bus.Score2), 2);
        chk("miss2.s1", int'(bus.Score1), 0);

        // Rallies 3..15: straight left misses, dy alternating.
        for (int n = 3; n <= 15; n++) begin
            for (int t = 1; t <= 218; t++) begin
                tick(n == 3 && t <= 51, 0, 0, 0, 0);
                if (t == 60) chk($sformatf("n%0d.play", n),
                                 int'(bus.oState), 1);
                if (n == 3 && t == 60)
                    chk("n3.p1", int'(bus.plat1Y), 211);
                if (t == 217)
                    chk_ball($sformatf("n%0d.end", n), 6,
                             (n % 2 == 1) ? 91 : 388);
            end
            chk($sformatf("n%0d.s2", n), int'(bus.Score2), n);
            chk($sformatf("n%0d.st", n), int'(bus.oState),
                (n == 15) ? 3 : 2);
        end
        chk("over.s1", int'(bus.Score1), 0);

        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 1, 0);
            chk($sformatf("frz%0d.st", i), int'(bus.oState), 3);
        end
        chk_ball("frz", 320, 240);
        chk("frz.p1", int'(bus.plat1Y), 211);
        chk("frz.p2", int'(bus.plat2Y), 151);
        chk("frz.s2", int'(bus.Score2), 15);
        bus.iServe = 1'b1;
        step();
        step();
        bus.iServe = 1'b0;
        chk("over.notick", int'(bus.oState), 3);

        tick(0, 0, 0, 0, 1);
        chk("restart.st", int'(bus.oState), 1);
        chk("restart.s2", int'(bus.Score2), 0);
        chk("restart.s1", int'(bus.Score1), 0);
        chk_ball("restart", 320, 240);
        tick(0, 0, 0, 0, 0);
        chk_ball("restart.t1", 322, 242);
        tick(0, 0, 0, 0, 0);
        chk_ball("restart.t2", 324, 244);

        // Reset wins over a coincident tick in PLAY.
        bus.iP1_up      = 1'b1;
        bus.iP2_dn      = 1'b1;
        bus.iFrame_tick = 1'b1;
        rst             = 1'b1;
        step();
        rst             = 1'b0;
        bus.iFrame_tick = 1'b0;
        bus.iP1_up      = 1'b0;
        bus.iP2_dn      = 1'b0;
        chk_ball("rst2", 320, 240);
        chk("rst2.p1y", int'(bus.plat1Y), 210);
        chk("rst2.p2y", int'(bus.plat2Y), 210);
        chk("rst2.h1", int'(bus.plat1H), 60);
        chk("rst2.h2", int'(bus.plat2H), 60);
        chk("rst2.x1", int'(bus.plat1X), 20);
        chk("rst2.x2", int'(bus.plat2X), 610);
        chk("rst2.s1", int'(bus.Score1), 0);
        chk("rst2.s2", int'(bus.Score2), 0);
        chk("rst2.st", int'(bus.oState), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
